// File: rtl/mix_columns_seq.sv
// mix_columns_seq: sequential AES MixColumns, one output byte per cycle over a
// shared xtime-based GF(2^8) datapath (field polynomial 9'h11B).
// Latency: 17 cycles from the start edge to the o_done edge; throughput one block per 18 cycles.
// Backpressure: none; i_start is sampled only in IDLE and ignored (not queued) while busy.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   i_start         - start request, sampled in IDLE
//   i_state[127:0]  - input state, byte k = i_state[127-8k -: 8], row r / col c is byte 4c+r
//   i_inv           - InvMixColumns select (only when INV_MIX_COLUMNS_EN is defined)
//   o_busy          - high while a block is in flight (RUN and DONE states)
//   o_done          - one-cycle pulse, o_state valid in that cycle
//   o_state[127:0]  - result, same byte order, held until the next done
//
// Optional feature macro: INV_MIX_COLUMNS_EN (adds i_inv and the inverse datapath).

module mix_columns_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [127:0] i_state,
`ifdef INV_MIX_COLUMNS_EN
  input  logic         i_inv,
`endif
  output logic         o_busy,
  output logic         o_done,
  output logic [127:0] o_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [127:0] in_q;
  logic [127:0] shadow_q;
  logic [3:0]   cnt_q;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // Byte k lives at bits [127-8k -: 8]; 127-8k == {~k, 3'b111} for 4-bit k.
  function automatic logic [7:0] get_byte(input logic [127:0] s, input logic [3:0] idx);
    return s[{~idx, 3'b111} -: 8];
  endfunction

  // Column operands for the byte being produced, rotated so a0 is row r.
  logic [1:0] col, row, row1, row2, row3;
  logic [7:0] a0, a1, a2, a3;
  logic [7:0] fwd_byte, out_byte;

  assign col  = cnt_q[3:2];
  assign row  = cnt_q[1:0];
  assign row1 = row + 2'd1;
  assign row2 = row + 2'd2;
  assign row3 = row + 2'd3;

  assign a0 = get_byte(in_q, {col, row});
  assign a1 = get_byte(in_q, {col, row1});
  assign a2 = get_byte(in_q, {col, row2});
  assign a3 = get_byte(in_q, {col, row3});

  // 02*a0 ^ 03*a1 ^ a2 ^ a3
  assign fwd_byte = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;

`ifdef INV_MIX_COLUMNS_EN
  logic       inv_q;
  logic [7:0] x2_0, x4_0, x8_0, x2_1, x4_1, x8_1;
  logic [7:0] x2_2, x4_2, x8_2, x2_3, x4_3, x8_3;
  logic [7:0] inv_byte;

  assign x2_0 = xtime(a0);  assign x4_0 = xtime(x2_0);  assign x8_0 = xtime(x4_0);
  assign x2_1 = xtime(a1);  assign x4_1 = xtime(x2_1);  assign x8_1 = xtime(x4_1);
  assign x2_2 = xtime(a2);  assign x4_2 = xtime(x2_2);  assign x8_2 = xtime(x4_2);
  assign x2_3 = xtime(a3);  assign x4_3 = xtime(x2_3);  assign x8_3 = xtime(x4_3);

  // 0E*a0 ^ 0B*a1 ^ 0D*a2 ^ 09*a3; x4_1 and x2_3 fall out of the XOR terms
  assign inv_byte = (x8_0 ^ x4_0 ^ x2_0)
                  ^ (x8_1 ^ x2_1 ^ a1)
                  ^ (x8_2 ^ x4_2 ^ a2)
                  ^ (x8_3 ^ a3);

  assign out_byte = inv_q ? inv_byte : fwd_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      inv_q <= 1'b0;
    end else if (state_q == IDLE && i_start) begin
      inv_q <= i_inv;
    end
  end
`else
  assign out_byte = fwd_byte;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_start) state_d = RUN;
      RUN:     if (cnt_q == 4'd15) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      in_q     <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      o_state  <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      state_q <= state_d;
      o_done  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            in_q   <= i_state;
            cnt_q  <= '0;
            o_busy <= 1'b1;
          end
        end
        RUN: begin
          shadow_q[{~cnt_q, 3'b111} -: 8] <= out_byte;
          // 15 -> 0 wrap coincides with the move to DONE
          cnt_q <= cnt_q + 4'd1;
        end
        DONE: begin
          o_state <= shadow_q;
          o_done  <= 1'b1;
          o_busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
module tb_mix_columns_seq;

  logic         clk;
  logic         rst;
  logic         i_start;
  logic [127:0] i_state;
  logic         i_inv;
  logic         o_busy;
  logic         o_done;
  logic [127:0] o_state;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  mix_columns_seq dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (i_start),
    .i_state (i_state),
`ifdef INV_MIX_COLUMNS_EN
    .i_inv   (i_inv),
`endif
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_state (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (o_done) done_cnt = done_cnt + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference: generic carry-less multiply then reduction by 0x11B.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'({7'b0, a}) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (15'h011B << (i - 8));
    return p[7:0];
  endfunction

  // Reference: circulant matrix times each column.
  function automatic logic [127:0] mix_model(input logic [127:0] s, input logic inv);
    logic [7:0]   coef [4];
    logic [127:0] res;
    logic [7:0]   acc;
    if (inv) begin
      coef[0] = 8'h0E; coef[1] = 8'h0B; coef[2] = 8'h0D; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gf_mul(coef[(j - r + 4) % 4], s[127 - 8*(4*c + j) -: 8]);
        res[127 - 8*(4*c + r) -: 8] = acc;
      end
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts one block from IDLE, scrambles the inputs after acceptance, and
  // waits (bounded) for o_done. lat counts edges after the start edge.
  task automatic run_op(input logic [127:0] st, input logic inv,
                        output logic [127:0] res, output int lat, output int busy_n);
    @(negedge clk);
    i_start = 1'b1; i_state = st; i_inv = inv;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0; i_state = rand128(); i_inv = ~inv;
    lat = -1; busy_n = 0; res = '0;
    for (int k = 0; k < 40; k++) begin
      if (o_busy) busy_n++;
      if (o_done) begin
        lat = k; res = o_state;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic full_check(input string tag, input logic [127:0] st, input logic inv,
                            input logic [127:0] exp);
    logic [127:0] res;
    int lat, busy_n;
    run_op(st, inv, res, lat, busy_n);
    check({tag, "_result"}, res, exp);
    check({tag, "_latency"}, 128'(lat), 128'd17);
    check({tag, "_busy_cycles"}, 128'(busy_n), 128'd17);
    @(negedge clk);
    check({tag, "_done_single"}, 128'(o_done), 128'd0);
    check({tag, "_state_held"}, o_state, exp);
  endtask

  initial begin
    logic [127:0] st_a, st_b, res, res2;
    logic [127:0] st_at [64];
    int lat, busy_n, d0, last_e, ndone;

    rst = 1'b1; i_start = 1'b0; i_state = '0; i_inv = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 128'(o_busy), 128'd0);
    check("reset_done", 128'(o_done), 128'd0);
    check("reset_state", o_state, 128'h0);
    rst = 1'b0;
    @(negedge clk);

    // FIPS single column
    full_check("fips_col", 128'hdb135345_01010101_01010101_01010101, 1'b0,
               128'h8e4da1bc_01010101_01010101_01010101);

    // Multi-column vector
    full_check("multi_col", 128'hd4bf5d30_f20a225c_c6c6c6c6_2d26314c, 1'b0,
               128'h046681e5_9fdc589d_c6c6c6c6_4d7ebdf8);

    // Random forward blocks against the model
    for (int i = 0; i < 4; i++) begin
      st_a = rand128();
      run_op(st_a, 1'b0, res, lat, busy_n);
      check("rand_fwd", res, mix_model(st_a, 1'b0));
    end

`ifdef INV_MIX_COLUMNS_EN
    full_check("inv_col", 128'h8e4da1bc_01010101_01010101_01010101, 1'b1,
               128'hdb135345_01010101_01010101_01010101);
    st_a = rand128();
    run_op(st_a, 1'b0, res, lat, busy_n);
    run_op(res, 1'b1, res2, lat, busy_n);
    check("round_trip", res2, st_a);
    check("round_trip_latency", 128'(lat), 128'd17);
`endif

    // Start pulse during RUN is ignored
    st_a = rand128(); st_b = rand128();
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    i_start = 1'b1; i_state = st_a; i_inv = 1'b0;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0; i_state = rand128();
    repeat (4) @(posedge clk);
    @(negedge clk);
    i_start = 1'b1; i_state = st_b;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    res = '0;
    for (int k = 0; k < 30; k++) begin
      if (o_done) begin res = o_state; break; end
      @(negedge clk);
    end
    check("ignored_start_result", res, mix_model(st_a, 1'b0));
    repeat (25) @(negedge clk);
    check("ignored_start_one_done", 128'(done_cnt - d0), 128'd1);

    // Reset mid-run
    d0 = done_cnt;
    i_start = 1'b1; i_state = rand128();
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 128'(o_busy), 128'd0);
    check("midrst_state", o_state, 128'h0);
    check("midrst_done", 128'(o_done), 128'd0);
    repeat (30) @(negedge clk);
    check("midrst_no_done", 128'(done_cnt - d0), 128'd0);
    st_a = rand128();
    full_check("after_rst", st_a, 1'b0, mix_model(st_a, 1'b0));

    // Back-to-back with i_start held high and i_state changing every cycle
    repeat (2) @(negedge clk);
    last_e = -1; ndone = 0;
    i_start = 1'b1;
    for (int e = 0; e < 60; e++) begin
      st_at[e] = rand128();
      i_state = st_at[e];
      @(posedge clk);
      @(negedge clk);
      if (o_done) begin
        ndone++;
        if (e >= 17) check("b2b_result", o_state, mix_model(st_at[e - 17], 1'b0));
        else         check("b2b_early_done", 128'(e), 128'd17);
        if (last_e < 0) check("b2b_first_latency", 128'(e), 128'd17);
        else            check("b2b_period", 128'(e - last_e), 128'd18);
        last_e = e;
      end
    end
    i_start = 1'b0;
    check("b2b_done_count", 128'(ndone), 128'd3);

    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
